tonegen_multi: RTL and testbench

//  NCH-channel square-wave tone generator on an Avalon-MM slave; successor to the single-channel tone block.

---
 rtl/tonegen_multi.sv | 137 +++++++++++++
 tb/tb_tonegen_multi.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/tonegen_multi.sv
// NCH-channel square-wave tone generator on an Avalon-MM slave, each channel with an optional ms duration timer.
// Optional mix output (XOR of all channels) is enabled by defining TONEGEN_MIX_EN.
module tonegen_multi #(
   parameter int FCLK = 100_000_000,
   parameter int NCH  = 4,
   parameter int AW   = $clog2(NCH) + 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [AW-1:0]   address,
   input  logic [31:0]     writedata,
   input  logic            write,
   input  logic            read,
   output logic [31:0]     readdata,
   output logic [NCH-1:0]  spkr,
   output logic [NCH-1:0]  busy
`ifdef TONEGEN_MIX_EN
   ,
   output logic            mix
`endif
);

   localparam int          PDIV   = FCLK / 1000;
   localparam int          PW     = (PDIV > 1) ? $clog2(PDIV) : 1;
   localparam logic [32:0] FCLK33 = 33'(FCLK);
   localparam logic [31:0] FHALF  = 32'(FCLK / 2);
   localparam logic [31:0] FMAX   = 32'(FCLK / 2 - 1);

   logic [PW-1:0]          pre;
   logic                   tick;
   logic                   sel;
   logic [AW-1:0]          ch_idx;
   logic [31:0]            freq_wr;
   logic [NCH-1:0][31:0]   freq_all;
   logic [NCH-1:0][30:0]   dur_all;
   logic [31:0]            rd_mux;

   assign sel     = address[0];
   assign ch_idx  = address >> 1;
   // Keep 2*freq below FCLK so at most one toggle can happen per cycle.
   assign freq_wr = (writedata >= FHALF) ? FMAX : writedata;

   // Shared ms prescaler; tick marks the wrap.
   assign tick = (pre == PW'(PDIV - 1));

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         pre <= '0;
      else
         pre <= tick ? '0 : pre + PW'(1);
   end

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic [31:0] freq_q;
      logic [32:0] acc_q;
      logic [30:0] dur_q;
      logic        spkr_q;
      logic [32:0] sum;
      logic        wr_freq;
      logic        wr_dur;
      logic        running;
      logic        dec;
      logic        expire;

      assign wr_freq = write && !sel && (ch_idx == AW'(c));
      assign wr_dur  = write &&  sel && (ch_idx == AW'(c));
      assign running = (freq_q != '0);
      assign dec     = tick && running && (dur_q != '0);
      assign expire  = dec && (dur_q == 31'd1);
      assign sum     = acc_q + {freq_q, 1'b0};

      // NOTE: per-channel state lives in flops, not RAM, so it is cleared by reset along with everything else.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            freq_q <= '0;
            acc_q  <= '0;
            dur_q  <= '0;
            spkr_q <= 1'b0;
         end else begin
            if (wr_dur)
               dur_q <= writedata[30:0];
            else if (dec)
               dur_q <= dur_q - 31'd1;

            // A bus write in the expiry cycle overrides the self-silence.
            if (wr_freq) begin
               freq_q <= freq_wr;
               acc_q  <= '0;
            end else if (expire && !wr_dur) begin
               freq_q <= '0;
               acc_q  <= '0;
               spkr_q <= 1'b0;
            end else if (!running) begin
               acc_q  <= '0;
               spkr_q <= 1'b0;
            end else if (sum >= FCLK33) begin
               acc_q  <= sum - FCLK33;
               spkr_q <= ~spkr_q;
            end else begin
               acc_q  <= sum;
            end
         end
      end

      assign spkr[c]     = spkr_q;
      assign busy[c]     = running;
      assign freq_all[c] = freq_q;
      assign dur_all[c]  = dur_q;
   end

   // NOTE: default assignment first so the read mux can never infer a latch.
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NCH; i++) begin
         if (ch_idx == AW'(i))
            rd_mux = sel ? {busy[i], dur_all[i]} : freq_all[i];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         readdata <= '0;
      else if (read)
         readdata <= rd_mux;
   end

`ifdef TONEGEN_MIX_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         mix <= 1'b0;
      else
         mix <= ^spkr;
   end
`endif

endmodule

// File: tb/tb_tonegen_multi.sv
// Scoreboard bench for tonegen_multi: closed-form tone model, driver pushes expectations, monitor pops per cycle.
module tb_tonegen_multi;

   localparam int FCLK = 100_000;
   localparam int NCH  = 4;
   localparam int AW   = 3;
   localparam int PDIV = FCLK / 1000;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [AW-1:0]   address = '0;
   logic [31:0]     writedata = '0;
   logic            write = 1'b0;
   logic            read = 1'b0;
   logic [31:0]     readdata;
   logic [NCH-1:0]  spkr;
   logic [NCH-1:0]  busy;
`ifdef TONEGEN_MIX_EN
   logic            mix;
`endif

   tonegen_multi #(.FCLK(FCLK), .NCH(NCH)) dut (
      .clk(clk), .reset(reset), .address(address), .writedata(writedata),
      .write(write), .read(read), .readdata(readdata), .spkr(spkr), .busy(busy)
`ifdef TONEGEN_MIX_EN
      , .mix(mix)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      longint         cyc;
      logic [NCH-1:0] spkr;
      logic [NCH-1:0] busy;
      logic [31:0]    rd;
      logic           mix;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail = 0;

   // Reference model: each channel is described by when its tone started, its frequency and its starting level.
   longint         m_f[NCH];
   longint         m_s[NCH];
   longint         m_dur[NCH];
   bit             m_b[NCH];
   longint         n;
   logic [31:0]    m_rd;
   logic [NCH-1:0] m_prev;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Level of channel c after edge k: number of FCLK crossings of k*2f since start, taken mod 2.
   function automatic bit spk_at(input int c, input longint k);
      if (k <= m_s[c]) return m_b[c];
      if (m_f[c] == 0) return 1'b0;
      return m_b[c] ^ bit'(((k - m_s[c]) * 2 * m_f[c] / FCLK) % 2);
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_f[c] = 0; m_s[c] = 0; m_dur[c] = 0; m_b[c] = 1'b0;
      end
      n = 0;
      m_rd = '0;
      m_prev = '0;
   endtask

   task automatic cycle(input logic wr, input logic [AW-1:0] a, input logic [31:0] wd, input logic rd);
      exp_t   e;
      longint nn;
      bit     tick;
      bit     dec;
      int     ch;
      bit     sel;
      @(negedge clk);
      write = wr; address = a; writedata = wd; read = rd;
      nn   = n + 1;
      tick = (nn % PDIV) == 0;
      ch   = int'(a >> 1);
      sel  = a[0];
      if (rd) begin
         if (ch >= NCH)  m_rd = '0;
         else if (sel)   m_rd = {m_f[ch] != 0, 31'(m_dur[ch])};
         else            m_rd = 32'(m_f[ch]);
      end
      for (int c = 0; c < NCH; c++) begin
         dec = tick && m_f[c] != 0 && m_dur[c] > 0;
         if (wr && ch == c && !sel) begin
            m_b[c] = spk_at(c, n);
            if (dec) m_dur[c]--;
            m_f[c] = (longint'(wd) >= FCLK / 2) ? FCLK / 2 - 1 : longint'(wd);
            m_s[c] = nn;
         end else if (wr && ch == c && sel) begin
            m_dur[c] = longint'(wd[30:0]);
         end else if (dec && m_dur[c] == 1) begin
            m_f[c] = 0; m_dur[c] = 0; m_s[c] = nn; m_b[c] = 1'b0;
         end else if (dec) begin
            m_dur[c]--;
         end
         e.spkr[c] = spk_at(c, nn);
         e.busy[c] = (m_f[c] != 0);
      end
      e.mix  = ^m_prev;
      m_prev = e.spkr;
      e.rd   = m_rd;
      e.cyc  = nn;
      q.push_back(e);
      n = nn;
   endtask

   task automatic idle(input int k);
      repeat (k) cycle(1'b0, '0, '0, 1'b0);
   endtask

   // Monitor: compare every registered output one time unit after each edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (!reset && q.size() > 0) begin
            e = q.pop_front();
            check($sformatf("spkr@%0d", e.cyc), 32'(spkr), 32'(e.spkr));
            check($sformatf("busy@%0d", e.cyc), 32'(busy), 32'(e.busy));
            check($sformatf("readdata@%0d", e.cyc), readdata, e.rd);
`ifdef TONEGEN_MIX_EN
            check($sformatf("mix@%0d", e.cyc), 32'(mix), 32'(e.mix));
`endif
         end
      end
   end

   initial begin
      bit          found;
      logic [2:0]  a;
      logic [31:0] wd;
      int          pick;
      model_reset();
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;

      // Idle after reset, with periodic reads of every register.
      for (int i = 0; i < 1000; i++)
         cycle(1'b0, 3'(i % 8), '0, (i % 50) == 0);

      // Channel 0 at 1 kHz, channel 1 at 300 Hz.
      cycle(1'b1, 3'd0, 32'd1000, 1'b0);
      idle(500);
      cycle(1'b1, 3'd2, 32'd300, 1'b0);
      idle(3000);
      cycle(1'b0, 3'd0, '0, 1'b1);
      cycle(1'b0, 3'd2, '0, 1'b1);

      // Channel 2 timed tone, then read its duration back.
      cycle(1'b1, 3'd5, 32'd3, 1'b0);
      cycle(1'b1, 3'd4, 32'd500, 1'b0);
      idle(420);
      cycle(1'b0, 3'd5, '0, 1'b1);
      cycle(1'b0, 3'd4, '0, 1'b1);

      // Channel 3: frequency write lands on the expiry edge.
      cycle(1'b1, 3'd7, 32'd1, 1'b0);
      cycle(1'b1, 3'd6, 32'd2000, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         if (((n + 1) % PDIV) == 0 && m_dur[3] == 1 && m_f[3] != 0) begin
            cycle(1'b1, 3'd6, 32'd777, 1'b0);
            found = 1'b1;
         end else begin
            idle(1);
         end
      end
      check("ch3 expiry window reached", 32'(found), 32'd1);
      cycle(1'b0, 3'd6, '0, 1'b1);
      cycle(1'b0, 3'd7, '0, 1'b1);
      idle(200);

      // Saturation and write/read collision on the same register.
      cycle(1'b1, 3'd2, 32'd60000, 1'b1);
      cycle(1'b0, 3'd2, '0, 1'b1);
      idle(300);

      // Randomized traffic.
      for (int i = 0; i < 2500; i++) begin
         a    = 3'($urandom_range(0, 7));
         pick = int'($urandom_range(0, 5));
         if (!a[0])
            wd = (pick == 0) ? 32'd0 : (pick == 1) ? 32'd50000 : (pick == 2) ? 32'd49999 :
                 (pick == 3) ? $urandom : 32'($urandom_range(1, 8000));
         else
            wd = (pick == 0) ? {1'b1, 31'($urandom_range(0, 4))} : 32'($urandom_range(0, 5));
         cycle($urandom_range(0, 7) == 0, a, wd, $urandom_range(0, 3) == 0);
      end

      // Asynchronous reset in the middle of a tone.
      cycle(1'b1, 3'd0, 32'd1000, 1'b0);
      cycle(1'b1, 3'd2, 32'd1000, 1'b0);
      idle(80);
      cycle(1'b0, 3'd7, '0, 1'b1);
      @(posedge clk);
      #3;
      reset = 1'b1; write = 1'b0; read = 1'b0;
      #1;
      q.delete();
      check("async reset spkr", 32'(spkr), 32'd0);
      check("async reset busy", 32'(busy), 32'd0);
      check("async reset readdata", readdata, 32'd0);
`ifdef TONEGEN_MIX_EN
      check("async reset mix", 32'(mix), 32'd0);
`endif
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      model_reset();
      cycle(1'b1, 3'd0, 32'd1000, 1'b0);
      cycle(1'b1, 3'd2, 32'd1000, 1'b0);
      cycle(1'b1, 3'd1, 32'd2, 1'b0);
      idle(400);

      repeat (2) @(posedge clk);
      #2;
      check("scoreboard drained", 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
